// File: rtl/trace_pkg.sv
// +----------------------------------------------------------------------------+
// | trace_pkg: shared types and record layout for the CPU trace buffer.         |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

package trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  localparam int REC_W   = 35;
  localparam int RES_LSB = 0;
  localparam int ACC_LSB = 8;
  localparam int IR_LSB  = 16;
  localparam int PC_LSB  = 24;
  localparam int OP_LSB  = 32;

  function automatic logic [REC_W-1:0] pack_rec(
    input logic [2:0] op,
    input logic [7:0] pc,
    input logic [7:0] ir,
    input logic [7:0] acc,
    input logic [7:0] res
  );
    return {op, pc, ir, acc, res};
  endfunction

endpackage

`default_nettype wire

// File: rtl/trace_fifo.sv
// +----------------------------------------------------------------------------+
// | trace_fifo: DEPTH x REC_W record store with wrapping pointers and count.   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic [REC_W-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [REC_W-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [REC_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage carries no reset; stale entries are never visible past the count.
  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/cpu_trace_buffer.sv
// +----------------------------------------------------------------------------+
// | cpu_trace_buffer: PC-triggered execution trace capture with drain port.    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module cpu_trace_buffer
  import trace_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               pc_in,
  input  logic [7:0]               ir_in,
  input  logic [7:0]               acc_in,
  input  logic [2:0]               alu_operation_in,
  input  logic [7:0]               alu_result_in,
  input  logic                     arm,
  input  logic                     stop,
  input  logic [7:0]               trig_pc,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [REC_W-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic [1:0]               state_out
);

  localparam int             CW        = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]  LAST_SLOT = CW'(DEPTH - 1);
  localparam logic [CW-1:0]  ONE       = CW'(1);

  state_e           state_q, state_d;
  logic [7:0]       last_pc_q, last_pc_d;
  logic             push, pop, clear;
  logic [REC_W-1:0] wr_rec, head_rec;
  logic [CW-1:0]    fifo_count;

  assign wr_rec = pack_rec(alu_operation_in, pc_in, ir_in, acc_in, alu_result_in);

  trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .clear_i (clear),
    .push_i  (push),
    .wdata_i (wr_rec),
    .pop_i   (pop),
    .rdata_o (head_rec),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      last_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      last_pc_q <= last_pc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    last_pc_d = last_pc_q;
    push      = 1'b0;
    clear     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arm) begin
          clear   = 1'b1;
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        // An abort takes precedence over a trigger hit in the same cycle.
        if (stop) begin
          clear   = 1'b1;
          state_d = ST_IDLE;
        end else if (pc_in == trig_pc) begin
          push      = 1'b1;
          last_pc_d = pc_in;
          state_d   = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (pc_in != last_pc_q) begin
          push      = 1'b1;
          last_pc_d = pc_in;
          if (fifo_count == LAST_SLOT) state_d = ST_DONE;
        end
        if (stop) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (fifo_count == '0 || (pop && fifo_count == ONE)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rd_valid  = (state_q == ST_DONE) && (fifo_count != '0);
  assign pop       = rd_valid && rd_ready;
  assign rd_data   = rd_valid ? head_rec : '0;
  assign count     = fifo_count;
  assign state_out = state_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_trace_buffer.sv
// +----------------------------------------------------------------------------+
// | tb_cpu_trace_buffer: scoreboard bench for the CPU trace buffer.            |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_cpu_trace_buffer;

  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    pc_in = '0, ir_in = '0, acc_in = '0, alu_result_in = '0, trig_pc = '0;
  logic [2:0]    alu_operation_in = '0;
  logic          arm = 1'b0, stop = 1'b0, rd_ready = 1'b0;
  logic          rd_valid;
  logic [34:0]   rd_data;
  logic [CW-1:0] count;
  logic [1:0]    state_out;

  int total = 0;
  int bad   = 0;
  int pops  = 0;
  logic [34:0] exp_q[$];

  cpu_trace_buffer #(.DEPTH(DEPTH)) dut (
    .clk              (clk),
    .reset            (reset),
    .pc_in            (pc_in),
    .ir_in            (ir_in),
    .acc_in           (acc_in),
    .alu_operation_in (alu_operation_in),
    .alu_result_in    (alu_result_in),
    .arm              (arm),
    .stop             (stop),
    .trig_pc          (trig_pc),
    .rd_ready         (rd_ready),
    .rd_valid         (rd_valid),
    .rd_data          (rd_data),
    .count            (count),
    .state_out        (state_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  // Monitor: every accepted record is compared against the scoreboard head.
  always @(negedge clk) begin
    if (!reset && rd_valid && rd_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pop_unexpected: got=%0h want=none", rd_data);
      end else begin
        check("rd_data", rd_data, exp_q.pop_front());
        pops++;
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cpu(input logic [7:0] pc);
    pc_in            = pc;
    ir_in            = 8'($urandom);
    acc_in           = 8'($urandom);
    alu_result_in    = 8'($urandom);
    alu_operation_in = 3'($urandom);
  endtask

  function automatic logic [34:0] rec_now();
    return {alu_operation_in, pc_in, ir_in, acc_in, alu_result_in};
  endfunction

  task automatic arm_session(input logic [7:0] trig, input logic [7:0] arm_pc);
    trig_pc = trig;
    arm     = 1'b1;
    set_cpu(arm_pc);
    cycle();
    arm = 1'b0;
    check("armed_state", state_out, 1);
    check("armed_count", count, 0);
  endtask

  task automatic drain(input bit random_ready, input int bound);
    int n = 0;
    while ((exp_q.size() != 0 || state_out != 2'd0) && n < bound) begin
      rd_ready = random_ready ? 1'($urandom) : 1'b1;
      cycle();
      n++;
    end
    rd_ready = 1'b0;
    check("drain_sb_empty", exp_q.size(), 0);
    check("drain_state", state_out, 0);
    check("drain_valid", rd_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pcs[64];
    bit rec_flag[64];
    logic [34:0] hold;

    // Reset and idle
    repeat (3) cycle();
    check("rst_state", state_out, 0);
    check("rst_count", count, 0);
    check("rst_valid", rd_valid, 0);
    check("rst_data", rd_data, 0);
    reset = 1'b0;
    cycle();
    for (int i = 0; i < 6; i++) begin
      stop     = 1'($urandom);
      rd_ready = 1'($urandom);
      set_cpu(8'(i));
      cycle();
      check("idle_state", state_out, 0);
      check("idle_count", count, 0);
      check("idle_valid", rd_valid, 0);
    end
    stop = 1'b0;
    rd_ready = 1'b0;

    // Basic trace: records are PC 2, 3, 4
    arm_session(8'd2, 8'd9);
    begin
      int seq[6] = '{0, 1, 2, 3, 3, 4};
      for (int i = 0; i < 6; i++) begin
        set_cpu(8'(seq[i]));
        if (i == 2 || i == 3 || i == 5) exp_q.push_back(rec_now());
        cycle();
      end
    end
    check("basic_count", count, 3);
    check("basic_state_cap", state_out, 2);
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    check("basic_state_done", state_out, 3);
    check("basic_count_done", count, 3);

    // Backpressure then a back-to-back drain
    hold = exp_q[0];
    for (int i = 0; i < 5; i++) begin
      rd_ready = 1'b0;
      cycle();
      check("bp_data", rd_data, hold);
      check("bp_pc", rd_data[31:24], 2);
      check("bp_count", count, 3);
    end
    pops = 0;
    rd_ready = 1'b1;
    cycle();
    check("burst_count1", count, 2);
    check("burst_pc1", rd_data[31:24], 3);
    cycle();
    check("burst_count2", count, 1);
    check("burst_pc2", rd_data[31:24], 4);
    cycle();
    rd_ready = 1'b0;
    check("burst_count3", count, 0);
    check("burst_pops", pops, 3);
    check("burst_valid", rd_valid, 0);
    check("burst_state", state_out, 0);

    // Full stop; arm with pc==trig in the arm cycle must not capture
    arm_session(8'd0, 8'd0);
    for (int p = 0; p <= 20; p++) begin
      set_cpu(8'(p));
      arm = (p == 8 || p == 18);
      if (p < DEPTH) exp_q.push_back(rec_now());
      cycle();
      arm = 1'b0;
      if (p == 8) begin
        check("arm_in_cap_state", state_out, 2);
        check("arm_in_cap_count", count, 9);
      end
      if (p == 15) begin
        check("full_state", state_out, 3);
        check("full_count", count, 16);
      end
      if (p == 18) begin
        check("arm_in_done_state", state_out, 3);
        check("arm_in_done_count", count, 16);
      end
    end
    check("full_count_end", count, 16);
    drain(1'b1, 400);

    // Stop in ARMED before trigger
    arm_session(8'hAA, 8'h00);
    set_cpu(8'd1);
    cycle();
    stop = 1'b1;
    set_cpu(8'd2);
    cycle();
    stop = 1'b0;
    check("stop_armed_state", state_out, 0);
    check("stop_armed_count", count, 0);
    set_cpu(8'hAA);
    cycle();
    check("stop_armed_after", count, 0);

    // Asynchronous reset in CAPTURE with five records
    arm_session(8'd5, 8'd0);
    for (int p = 5; p < 10; p++) begin
      set_cpu(8'(p));
      cycle();
    end
    check("pre_rst_count", count, 5);
    check("pre_rst_state", state_out, 2);
    #2 reset = 1'b1;
    #1;
    check("async_rst_state", state_out, 0);
    check("async_rst_count", count, 0);
    check("async_rst_valid", rd_valid, 0);
    check("async_rst_data", rd_data, 0);
    exp_q.delete();
    cycle();
    reset = 1'b0;
    cycle();
    check("post_rst_state", state_out, 0);

    // Randomized sessions checked against a sequence-level model
    for (int s_i = 0; s_i < 25; s_i++) begin
      int len, s, t, n;
      logic [7:0] trig;
      trig = 8'($urandom_range(0, 7));
      len  = $urandom_range(3, 50);
      s    = $urandom_range(0, len - 1);
      for (int i = 0; i < len; i++) pcs[i] = $urandom_range(0, 7);
      t = -1;
      for (int i = 0; i < s; i++) if (t < 0 && pcs[i] == int'(trig)) t = i;
      if (t < 0 && pcs[s] == int'(trig)) pcs[s] = int'(trig) ^ 1;
      // Records: trigger hit, then every PC change, up to the stop cycle, capped at DEPTH
      n = 0;
      for (int i = 0; i < len; i++) begin
        rec_flag[i] = (t >= 0) && (i >= t) && (i <= s) && (n < DEPTH) &&
                      (i == t || pcs[i] != pcs[i-1]);
        if (rec_flag[i]) n++;
      end
      arm_session(trig, 8'($urandom_range(0, 7)));
      for (int i = 0; i < len; i++) begin
        set_cpu(8'(pcs[i]));
        stop = (i == s);
        if (rec_flag[i]) exp_q.push_back(rec_now());
        cycle();
      end
      stop = 1'b0;
      check("rnd_count", count, n);
      check("rnd_state", state_out, (n == 0) ? 0 : 3);
      drain(1'b1, 400);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
